mant_round_seq: RTL and testbench
=================================

# mant_round_seq

Multi-cycle rounding-increment sequencer for the FPU mantissa path. It takes a normalised mantissa, exponent and round-up decision from the rounding-decision stage, and drives a single shared 4-bit incrementer slice nibble by nibble, LSB first. It renormalises on mantissa carry-out and returns the rounded mantissa and exponent to the pack stage through a valid/ready handshake.

## Interface
- W, 24: mantissa width in bits; multiple of 4, ≥ 8.
- EW, 8: exponent width in bits.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  block can accept an operand; high only in IDLE.
- MANT_IN  input  W  mantissa to be rounded.
- EXP_IN  input  EW  exponent.
- INC  input  1  round-up decision; 1 means add one ulp.
- OUT_VALID  output  1  result valid; high only in DONE.
- OUT_READY  input  1  downstream accepts the result.
- MANT_OUT  output  W  rounded mantissa.
- EXP_OUT  output  EW  rounded exponent.
- CARRY_OUT  output  1  the increment carried out of the MSB and the result was renormalised.
- OVF  output  1  exponent reached all-ones; the result is infinity.

## Operation
- States: IDLE, STEP, ADJ, DONE. Nibble index `idx` runs 0..N-1, where N = W/4.
- IDLE: IN_READY=1. On IN_VALID, latch the operands and clear the flags.
  - If INC=0, go to DONE with the operands unchanged.
  - If INC=1, go to STEP with idx=0 and carry=1.
- STEP: the slice gets A = mant[4*idx+3:4*idx] and CIN = carry. S is written back into that nibble and carry is set to COUT.
  - If COUT=0 and the early-exit feature is enabled, go to DONE.
  - Else if idx = N-1, go to ADJ if COUT=1, or to DONE if COUT=0.
  - Else idx increments and the block stays in STEP.
- ADJ (entered only on carry out of the MSB): mant = {1'b1, (W-1)'b0}, CARRY_OUT=1.
  - If EXP_IN ≥ 2^EW-2, then EXP_OUT = all-ones and OVF=1.
  - Otherwise EXP_OUT = EXP_IN+1.
  - Next state is DONE.
- DONE: OUT_VALID=1. Outputs are held stable until OUT_READY=1, then the block goes to IDLE.
- The operand register is never touched outside STEP and ADJ. No new operand is accepted until the current result has been taken.
- Reset mid-operation: the operation is abandoned, no OUT_VALID is produced, and the block returns to IDLE.

## Timing
- After the first reset cycle: state IDLE, IN_READY=1, OUT_VALID=0. MANT_OUT, EXP_OUT, CARRY_OUT and OVF are all 0.
- The operand is accepted at cycle 0 (IN_VALID & IN_READY at the edge).
- INC=0: OUT_VALID at cycle 1.
- INC=1, carry dies in nibble j (with early exit): STEP runs in cycles 1..j+1 and OUT_VALID is at cycle j+2.
- INC=1, carry out of the MSB: STEP runs in cycles 1..N, ADJ at N+1, OUT_VALID at N+2.
- OUT_VALID & OUT_READY at cycle k: IDLE at k+1, and the next operand can be accepted at the edge ending k+1.
- Minimum initiation interval is latency + 1.
- IN_READY is registered-state decoded (purely combinational from state). It never depends combinationally on IN_VALID or OUT_READY.

## Configuration
- ROUND_EARLY_EXIT_EN defined: STEP terminates on the first COUT=0. Latency depends on the data.
- ROUND_EARLY_EXIT_EN undefined: STEP always visits all N nibbles. Latency is fixed at N+1 (no MSB carry) or N+2 (MSB carry) for INC=1, and 1 for INC=0.
- Results are bit-identical with and without the macro.

## Structure
- Shared package fpu_round_pkg holds:
  - the state enum (IDLE, STEP, ADJ, DONE);
  - NIBBLE = 4;
  - the helper function computing N from W.
- One sub-module instance: the team's existing 4-bit incrementer slice `ocla` (ports A, CIN, COUT, S). Do not duplicate its carry logic inline.
- The index counter is $clog2(N) bits wide.

## Test plan
- W=24, INC=0, MANT_IN=0x123456, EXP_IN=0x40 -> OUT_VALID at cycle 1, MANT_OUT=0x123456, EXP_OUT=0x40, CARRY_OUT=0, OVF=0.
- INC=1, MANT_IN=0x00000F, EXP_IN=0x10, early exit enabled -> MANT_OUT=0x000010, EXP_OUT=0x10, OUT_VALID at cycle 3. Same stimulus with the macro undefined -> same result, OUT_VALID at cycle 7.
- INC=1, MANT_IN=0xFFFFFF, EXP_IN=0x7E -> MANT_OUT=0x800000, EXP_OUT=0x7F, CARRY_OUT=1, OVF=0, OUT_VALID at cycle 8.
- INC=1, MANT_IN=0xFFFFFF, EXP_IN=0xFE -> EXP_OUT=0xFF, OVF=1, CARRY_OUT=1.
- Hold OUT_READY=0 for 3 cycles in DONE, with a second IN_VALID asserted throughout -> outputs stable, IN_READY=0, second operand accepted only after the handshake.
- Assert RST during STEP (MANT_IN=0xFFFFFF, INC=1) -> no OUT_VALID; next cycle IDLE with all outputs 0; a fresh operand then completes correctly.

Source files
------------

// File: rtl/fpu_round_pkg.sv
// Shared definitions for the FPU rounding-increment sequencer:
// the state type, the nibble width and the nibble-count helper.
package fpu_round_pkg;

   localparam int unsigned NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      ADJ  = 2'd2,
      DONE = 2'd3
   } round_state_t;

   function automatic int unsigned nibble_count(input int unsigned width);
      return width / NIBBLE;
   endfunction

endpackage

// File: rtl/mant_round_seq_ocla.sv
// Shared 4-bit incrementer slice: S = A + CIN, COUT is the carry out of bit 3.
module ocla (
   input  logic [3:0] A,
   input  logic       CIN,
   output logic       COUT,
   output logic [3:0] S
);

   assign {COUT, S} = {1'b0, A} + {4'b0000, CIN};

endmodule

// File: rtl/mant_round_seq.sv
// Nibble-serial rounding-increment sequencer with renormalisation on MSB carry.
// Optional macro ROUND_EARLY_EXIT_EN: stop stepping at the first nibble that does not carry.
module mant_round_seq
   import fpu_round_pkg::*;
#(
   parameter int W  = 24,
   parameter int EW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [W-1:0]  MANT_IN,
   input  logic [EW-1:0] EXP_IN,
   input  logic          INC,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [W-1:0]  MANT_OUT,
   output logic [EW-1:0] EXP_OUT,
   output logic          CARRY_OUT,
   output logic          OVF
);

   localparam int unsigned   N        = nibble_count(W);
   localparam int unsigned   IW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [EW-1:0] EXP_SAT  = {{(EW-1){1'b1}}, 1'b0};

   round_state_t  r_state;
   round_state_t  w_next;
   logic [W-1:0]  r_mant;
   logic [EW-1:0] r_exp;
   logic          r_carry;
   logic          r_cout_flag;
   logic          r_ovf;
   logic [IW-1:0] r_idx;

   logic [IW+1:0] w_sh;
   logic [W-1:0]  w_shifted;
   logic [W-1:0]  w_wr_mant;
   logic [3:0]    w_a;
   logic [3:0]    w_s;
   logic          w_cout;

   // Nibble select/merge by shifting avoids a variable-index part select.
   assign w_sh      = {r_idx, 2'b00};
   assign w_shifted = r_mant >> w_sh;
   assign w_a       = w_shifted[3:0];
   assign w_wr_mant = (r_mant & ~(W'(4'hF) << w_sh)) | (W'(w_s) << w_sh);

   ocla u_ocla (
      .A    (w_a),
      .CIN  (r_carry),
      .COUT (w_cout),
      .S    (w_s)
   );

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (IN_VALID) w_next = INC ? STEP : DONE;
         STEP: begin
            if (r_idx == LAST_IDX) w_next = w_cout ? ADJ : DONE;
`ifdef ROUND_EARLY_EXIT_EN
            if (!w_cout) w_next = DONE;
`endif
         end
         ADJ:  w_next = DONE;
         DONE: if (OUT_READY) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_mant      <= '0;
         r_exp       <= '0;
         r_carry     <= 1'b0;
         r_cout_flag <= 1'b0;
         r_ovf       <= 1'b0;
         r_idx       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (IN_VALID) begin
                  r_mant      <= MANT_IN;
                  r_exp       <= EXP_IN;
                  r_cout_flag <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_carry     <= 1'b1;
                  r_idx       <= '0;
               end
            end
            STEP: begin
               r_mant  <= w_wr_mant;
               r_carry <= w_cout;
               if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            end
            ADJ: begin
               r_mant      <= {1'b1, {(W-1){1'b0}}};
               r_cout_flag <= 1'b1;
               if (r_exp >= EXP_SAT) begin
                  r_exp <= '1;
                  r_ovf <= 1'b1;
               end else begin
                  r_exp <= r_exp + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign IN_READY  = (r_state == IDLE);
   assign OUT_VALID = (r_state == DONE);
   assign MANT_OUT  = r_mant;
   assign EXP_OUT   = r_exp;
   assign CARRY_OUT = r_cout_flag;
   assign OVF       = r_ovf;

endmodule

// File: tb/tb_mant_round_seq.sv
// Self-checking bench for mant_round_seq against an arithmetic reference model.
module tb_mant_round_seq;

   localparam int W  = 24;
   localparam int EW = 8;
   localparam int N  = W / 4;
   localparam int TIMEOUT = 64;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          IN_VALID = 1'b0;
   logic          INC = 1'b0;
   logic          OUT_READY = 1'b0;
   logic [W-1:0]  MANT_IN = '0;
   logic [EW-1:0] EXP_IN = '0;
   logic          IN_READY;
   logic          OUT_VALID;
   logic [W-1:0]  MANT_OUT;
   logic [EW-1:0] EXP_OUT;
   logic          CARRY_OUT;
   logic          OVF;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   mant_round_seq #(.W(W), .EW(EW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .MANT_IN   (MANT_IN),
      .EXP_IN    (EXP_IN),
      .INC       (INC),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .MANT_OUT  (MANT_OUT),
      .EXP_OUT   (EXP_OUT),
      .CARRY_OUT (CARRY_OUT),
      .OVF       (OVF)
   );

   // Reference: plain addition of one ulp, renormalise on overflow, latency from nibble count.
   task automatic model(input logic [W-1:0] m, input logic [EW-1:0] e, input logic inc,
                        output logic [W-1:0] mo, output logic [EW-1:0] eo,
                        output logic co, output logic ov, output int lat);
      logic [W:0] sum;
      int j;
      sum = {1'b0, m} + {{W{1'b0}}, inc};
      co = 1'b0; ov = 1'b0; eo = e; mo = sum[W-1:0];
      if (!inc) begin
         lat = 1;
      end else if (sum[W]) begin
         co = 1'b1;
         mo = '0;
         mo[W-1] = 1'b1;
         lat = N + 2;
         if (int'(e) >= (1 << EW) - 2) begin
            eo = '1;
            ov = 1'b1;
         end else begin
            eo = e + 1'b1;
         end
      end else begin
`ifdef ROUND_EARLY_EXIT_EN
         j = 0;
         while (j < N && m[4*j +: 4] == 4'hF) j++;
         lat = j + 2;
`else
         j = N;
         lat = j + 1;
`endif
      end
   endtask

   // Drives one operand from IDLE, returns the observed result and latency, then takes it.
   task automatic run_op(input logic [W-1:0] m, input logic [EW-1:0] e, input logic inc,
                         output logic [W-1:0] mo, output logic [EW-1:0] eo,
                         output logic co, output logic ov, output int lat);
      IN_VALID = 1'b1; MANT_IN = m; EXP_IN = e; INC = inc;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      lat = 1;
      while (!OUT_VALID && lat < TIMEOUT) begin
         @(posedge CLK); #1;
         lat++;
      end
      mo = MANT_OUT; eo = EXP_OUT; co = CARRY_OUT; ov = OVF;
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if ({IN_READY, OUT_VALID} !== 2'b10) begin
         errors++;
         $display("FAIL reset_hs: ready=%b valid=%b, expected ready=1 valid=0", IN_READY, OUT_VALID);
      end
      checks++;
      if ({MANT_OUT, EXP_OUT, CARRY_OUT, OVF} !== '0) begin
         errors++;
         $display("FAIL reset_out: mant=%h exp=%h co=%b ovf=%b, expected all zero",
                  MANT_OUT, EXP_OUT, CARRY_OUT, OVF);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   task automatic test_directed();
      logic [W-1:0]  tm[7];
      logic [EW-1:0] te[7];
      logic          ti[7];
      logic [W-1:0]  mo, emo;
      logic [EW-1:0] eo, eeo;
      logic          co, eco, ov, eov;
      int            lat, elat;
      tm[0] = 24'h123456; te[0] = 8'h40; ti[0] = 1'b0;
      tm[1] = 24'h00000F; te[1] = 8'h10; ti[1] = 1'b1;
      tm[2] = 24'hFFFFFF; te[2] = 8'h7E; ti[2] = 1'b1;
      tm[3] = 24'hFFFFFF; te[3] = 8'hFE; ti[3] = 1'b1;
      tm[4] = 24'hFFFFFF; te[4] = 8'hFD; ti[4] = 1'b1;
      tm[5] = 24'hFFFFFF; te[5] = 8'hFF; ti[5] = 1'b1;
      tm[6] = 24'h7FFFFF; te[6] = 8'h01; ti[6] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         model(tm[i], te[i], ti[i], emo, eeo, eco, eov, elat);
         run_op(tm[i], te[i], ti[i], mo, eo, co, ov, lat);
         checks++;
         if ({mo, eo, co, ov} !== {emo, eeo, eco, eov}) begin
            errors++;
            $display("FAIL directed_%0d: mant=%h exp=%h co=%b ovf=%b, expected mant=%h exp=%h co=%b ovf=%b",
                     i, mo, eo, co, ov, emo, eeo, eco, eov);
         end
         checks++;
         if (lat != elat) begin
            errors++;
            $display("FAIL directed_lat_%0d: latency=%0d, expected %0d", i, lat, elat);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0]  m, mo, emo;
      logic [EW-1:0] e, eo, eeo;
      logic          inc, co, eco, ov, eov;
      int            lat, elat, k;
      for (int i = 0; i < 60; i++) begin
         m = W'($urandom);
         k = $urandom_range(0, N);
         for (int b = 0; b < k; b++) m[4*b +: 4] = 4'hF;
         case ($urandom_range(0, 3))
            0:       e = 8'hFE - EW'($urandom_range(0, 1));
            1:       e = 8'hFF;
            default: e = EW'($urandom);
         endcase
         inc = ($urandom_range(0, 3) != 0);
         model(m, e, inc, emo, eeo, eco, eov, elat);
         run_op(m, e, inc, mo, eo, co, ov, lat);
         checks++;
         if ({mo, eo, co, ov, lat} !== {emo, eeo, eco, eov, elat}) begin
            errors++;
            $display("FAIL random_%0d: in=%h/%h/%b got mant=%h exp=%h co=%b ovf=%b lat=%0d, expected mant=%h exp=%h co=%b ovf=%b lat=%0d",
                     i, m, e, inc, mo, eo, co, ov, lat, emo, eeo, eco, eov, elat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]  hm, emo;
      logic [EW-1:0] he, eeo;
      logic          hc, ho, eco, eov;
      int            lat, elat;
      IN_VALID = 1'b1; MANT_IN = 24'h0000FF; EXP_IN = 8'h22; INC = 1'b1;
      @(posedge CLK); #1;
      MANT_IN = 24'h123ABC; EXP_IN = 8'h33; INC = 1'b1;
      lat = 1;
      while (!OUT_VALID && lat < TIMEOUT) begin
         @(posedge CLK); #1;
         lat++;
      end
      hm = MANT_OUT; he = EXP_OUT; hc = CARRY_OUT; ho = OVF;
      model(24'h0000FF, 8'h22, 1'b1, emo, eeo, eco, eov, elat);
      checks++;
      if ({hm, he, hc, ho, lat} !== {emo, eeo, eco, eov, elat}) begin
         errors++;
         $display("FAIL bp_first: mant=%h exp=%h co=%b ovf=%b lat=%0d, expected mant=%h exp=%h co=%b ovf=%b lat=%0d",
                  hm, he, hc, ho, lat, emo, eeo, eco, eov, elat);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         checks++;
         if ({OUT_VALID, IN_READY, MANT_OUT, EXP_OUT, CARRY_OUT, OVF} !== {1'b1, 1'b0, hm, he, hc, ho}) begin
            errors++;
            $display("FAIL bp_hold_%0d: valid=%b ready=%b mant=%h exp=%h, expected valid=1 ready=0 mant=%h exp=%h",
                     c, OUT_VALID, IN_READY, MANT_OUT, EXP_OUT, hm, he);
         end
      end
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      checks++;
      if ({IN_READY, OUT_VALID} !== 2'b10) begin
         errors++;
         $display("FAIL bp_idle: ready=%b valid=%b, expected ready=1 valid=0", IN_READY, OUT_VALID);
      end
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      lat = 1;
      while (!OUT_VALID && lat < TIMEOUT) begin
         @(posedge CLK); #1;
         lat++;
      end
      model(24'h123ABC, 8'h33, 1'b1, emo, eeo, eco, eov, elat);
      checks++;
      if ({MANT_OUT, EXP_OUT, CARRY_OUT, OVF, lat} !== {emo, eeo, eco, eov, elat}) begin
         errors++;
         $display("FAIL bp_second: mant=%h exp=%h co=%b ovf=%b lat=%0d, expected mant=%h exp=%h co=%b ovf=%b lat=%0d",
                  MANT_OUT, EXP_OUT, CARRY_OUT, OVF, lat, emo, eeo, eco, eov, elat);
      end
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0]  mo, emo;
      logic [EW-1:0] eo, eeo;
      logic          co, eco, ov, eov;
      int            lat, elat, seen;
      IN_VALID = 1'b1; MANT_IN = 24'hFFFFFF; EXP_IN = 8'h50; INC = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      checks++;
      if ({IN_READY, OUT_VALID, MANT_OUT, EXP_OUT, CARRY_OUT, OVF} !== {1'b1, 1'b0, {W{1'b0}}, {EW{1'b0}}, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rst_mid_state: ready=%b valid=%b mant=%h exp=%h co=%b ovf=%b, expected ready=1 and all else 0",
                  IN_READY, OUT_VALID, MANT_OUT, EXP_OUT, CARRY_OUT, OVF);
      end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge CLK); #1;
         if (OUT_VALID) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_mid_novalid: out_valid cycles=%0d, expected 0", seen);
      end
      model(24'h0FFFFF, 8'h20, 1'b1, emo, eeo, eco, eov, elat);
      run_op(24'h0FFFFF, 8'h20, 1'b1, mo, eo, co, ov, lat);
      checks++;
      if ({mo, eo, co, ov, lat} !== {emo, eeo, eco, eov, elat}) begin
         errors++;
         $display("FAIL rst_mid_fresh: mant=%h exp=%h co=%b ovf=%b lat=%0d, expected mant=%h exp=%h co=%b ovf=%b lat=%0d",
                  mo, eo, co, ov, lat, emo, eeo, eco, eov, elat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
